// File: rtl/mem_port_pkg.sv
// Shared encodings for the core-to-memory port controller.
// Size codes, FSM states and the default read latency.
package mem_port_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  localparam int READ_LAT_DEF = 2;

  function automatic logic bad_req(
    input size_t      sz,
    input logic [1:0] ofs
  );
    return (sz == SZ_X)
        || (sz == SZ_H && ofs[0])
        || (sz == SZ_W && ofs != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane enables, store replication and load align/extend.
// Purely combinational; shared by request and response paths.
module mem_lane_align
  import mem_port_pkg::*;
(
  input  size_t       size,
  input  logic        sgn,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  b_en,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [31:0] sh;

  always_comb begin
    sh   = rdata >> {ofs, 3'b000};
    b_en = 4'b1111;
    wrep = wdata;
    rext = sh;
    unique case (1'b1)
      (size == SZ_B): begin
        b_en = 4'b0001 << ofs;
        wrep = {4{wdata[7:0]}};
        rext = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      (size == SZ_H): begin
        b_en = 4'b0011 << ofs;
        wrep = {2{wdata[15:0]}};
        rext = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: begin
        b_en = 4'b1111;
        wrep = wdata;
        rext = sh;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding load/store port between core and memory.
// IDLE accepts, ISSUE drives the memory, RESP pulses the result.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              gclk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_b_en,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              mem_error
);

  state_t            state;
  logic [2:0]        cnt;
  logic              err_q;
  logic              wen_q;
  logic              sgn_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;

  logic              idle;
  logic              last;
  size_t             sel_size;
  logic              sel_sgn;
  logic [1:0]        sel_ofs;
  logic [3:0]        ben;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] rext;

  assign idle      = (state == IDLE);
  assign req_ready = idle && !reset;

  // Request fields feed the aligner at accept, latched copy afterwards.
  assign sel_size = idle ? size_t'(req_size) : size_q;
  assign sel_sgn  = idle ? req_signed : sgn_q;
  assign sel_ofs  = idle ? req_addr[1:0] : addr_q[1:0];

  assign last = wen_q || (cnt == 3'(READ_LAT - 1));

  mem_lane_align u_align (
    .size  (sel_size),
    .sgn   (sel_sgn),
    .ofs   (sel_ofs),
    .wdata (req_wdata),
    .rdata (mem_rdata),
    .b_en  (ben),
    .wrep  (wrep),
    .rext  (rext)
  );

  always_ff @(posedge gclk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      err_q     <= 1'b0;
      wen_q     <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_B;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_b_en  <= 4'b0000;
      mem_w_en  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            wen_q  <= req_wen;
            sgn_q  <= req_signed;
            size_q <= size_t'(req_size);
            if (bad_req(size_t'(req_size), req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ISSUE;
              cnt       <= 3'd0;
              err_q     <= 1'b0;
              mem_addr  <= req_addr;
              mem_wdata <= wrep;
              mem_b_en  <= ben;
              mem_w_en  <= req_wen;
            end
          end
        end
        ISSUE: begin
          if (mem_error) err_q <= 1'b1;
          if (!mem_stall) cnt <= cnt + 3'd1;
          if (!mem_stall && last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= err_q | mem_error;
            rsp_rdata <= (wen_q | err_q | mem_error) ? '0 : rext;
            mem_b_en  <= 4'b0000;
            mem_w_en  <= 1'b0;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter READ_LAT, default 2, number of non-stalled cycles the memory port is driven before read data is captured; legal range 1..7.
REQ-004 gclk  in  1  global clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  core request valid.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_wen  in  1  1 = store, 0 = load.
REQ-010 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_signed  in  1  sign-extend load result.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors.
REQ-015 rsp_error  out  1  misaligned, illegal size or memory error.
REQ-016 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and lane-replicated write data.
REQ-017 mem_b_en  out  4  byte-lane enables; mem_w_en  out  1  write enable.
REQ-018 mem_rdata  in  DATA_W; mem_stall  in  1; mem_error  in  1  memory return signals.

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, RESP; req_ready SHALL be 1 only in IDLE with reset low.
REQ-020 On req_valid && req_ready, all req_* fields SHALL be latched; the latched copy is used until RESP.
REQ-021 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go IDLE->RESP with rsp_error=1; no memory access is made.
REQ-022 Otherwise IDLE->ISSUE; mem_b_en SHALL be nonzero only in ISSUE.
REQ-023 mem_b_en SHALL be byte: 0001<<addr[1:0]; half: 0011<<addr[1:0]; word: 1111.
REQ-024 mem_wdata SHALL be byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata; mem_w_en = latched req_wen during ISSUE, else 0.
REQ-025 mem_addr SHALL equal the latched req_addr during ISSUE and hold its last value otherwise.
REQ-026 A 3-bit cycle counter SHALL advance only on ISSUE cycles with mem_stall=0; a store leaves ISSUE after 1 such cycle, a load after READ_LAT such cycles.
REQ-027 A load SHALL capture mem_rdata on its final counted ISSUE cycle, shift right by 8*addr[1:0], then zero- or sign-extend from bit 7 (byte) or bit 15 (half) per req_signed.
REQ-028 mem_error sampled high on any ISSUE cycle SHALL set a sticky error flag reported as rsp_error.
REQ-029 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_rdata/rsp_error valid only while rsp_valid=1.
REQ-030 Latency from acceptance cycle 0 with no stalls: store rsp_valid at cycle 2, load at cycle READ_LAT+1, error at cycle 1; each stall cycle adds one.
REQ-031 Back-to-back: the next request SHALL be accepted in the cycle following RESP, at the earliest.

Reset
REQ-032 While reset=1 at a clock edge: state IDLE, counter 0, error flag 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, mem_b_en 0, mem_w_en 0, mem_addr 0, mem_wdata 0.
REQ-033 Reset during ISSUE SHALL abort the access with no response and no further memory enables.

Structure
REQ-034 Package mem_port_pkg SHALL hold the req_size encodings, the FSM state encoding and the READ_LAT default.
REQ-035 Byte-lane enable, write replication and load align/extend logic SHALL be one combinational sub-module mem_lane_align.

Verification
REQ-036 Word store addr 0x10, wdata 0xDEADBEEF -> cycle 1 mem_b_en=1111, mem_w_en=1; cycle 2 rsp_valid=1, rsp_error=0.
REQ-037 Memory word 0x80F0_1234 at 0x20; signed byte load 0x22 -> rsp_rdata 0xFFFFFFF0 at cycle 3; unsigned half load 0x22 -> 0x000080F0.
REQ-038 Half load addr 0x21 -> rsp_valid and rsp_error=1 at cycle 1; mem_b_en stays 0000 throughout.
REQ-039 Word load with mem_stall high for 2 ISSUE cycles -> rsp_valid at cycle 5; mem_addr held stable throughout.
REQ-040 mem_error=1 during a store's ISSUE cycle -> rsp_error=1 with rsp_valid; the next request is accepted normally with rsp_error=0.
REQ-041 reset=1 on ISSUE cycle 1 of a load -> no rsp_valid, mem_b_en=0 from the next cycle, req_ready=1 once reset is low.
